// File: rtl/clock_pkg.sv
// clock_pkg: run/stop state type and default timing constants shared by the clock stages
package clock_pkg;
    typedef enum logic {STOPPED, RUNNING} state_t;
    localparam int CLK_FREQ_DEF = 50_000_000;
    localparam int DEBOUNCE_DEF = 500_000;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer plus debouncer for an active-low push-button, pulsing once per press
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic resetN,
    input  logic keyN,
    output logic level,
    output logic pressPulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic accept;
    // the synced value has differed from the level for DEBOUNCE_CYCLES cycles as of this edge
    assign accept = (sync[1] != level) && (cnt == LAST);
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            sync       <= 2'b11;
            level      <= 1'b1;
            cnt        <= '0;
            pressPulse <= 1'b0;
        end else begin
            sync       <= {sync[0], keyN};
            cnt        <= (sync[1] == level || accept) ? '0 : cnt + CW'(1);
            level      <= accept ? sync[1] : level;
            pressPulse <= accept && !sync[1];
        end
endmodule

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: divides clk into one-cycle seconds pulses with start/stop, clear and fast-set control
module sec_tick_gen
    import clock_pkg::*;
#(
    parameter int CLK_FREQ        = CLK_FREQ_DEF,
    parameter int FAST_DIV        = 10,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic resetN,
    input  logic startStopN,
    input  logic clearN,
    input  logic fastSet,
    output logic CarryInSec,
    output logic running,
    output logic clearOutN
);
    localparam int CW = $clog2(CLK_FREQ);
    localparam logic [CW-1:0] LAST_NORM = CW'(CLK_FREQ - 1);
    localparam logic [CW-1:0] LAST_FAST = CW'(CLK_FREQ / FAST_DIV - 1);
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, last;
    logic ss_event, clr_event, wrap;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
        .clk, .resetN, .keyN(startStopN), .level(), .pressPulse(ss_event)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk, .resetN, .keyN(clearN), .level(), .pressPulse(clr_event)
    );
    assign last    = fastSet ? LAST_FAST : LAST_NORM;
    // >= rather than == so a switch to fast mode with cnt above the new terminal wraps at once
    assign wrap    = (state == RUNNING) && (cnt >= last);
    assign running = (state == RUNNING);
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ss_event) state_nxt = (state == RUNNING) ? STOPPED : RUNNING;
        if (state == RUNNING) cnt_nxt = wrap ? '0 : cnt + CW'(1);
        if (clr_event) begin
            state_nxt = STOPPED;
            cnt_nxt   = '0;
        end
    end
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            state      <= STOPPED;
            cnt        <= '0;
            CarryInSec <= 1'b0;
            clearOutN  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            CarryInSec <= wrap;
            clearOutN  <= ~clr_event;
        end
endmodule

// File: doc/sec_tick_gen.md
# sec_tick_gen

Upstream timebase for the seconds counter. It divides the board clock into one-clock-wide seconds pulses on `CarryInSec`, which the seconds counter consumes on its rising edge. It also provides start/stop and clear control from two debounced push-buttons, and a fast-set mode. Clear drives an active-low reset to the counter chain so seconds, minutes and hours restart together.

## Interface
- `CLK_FREQ`, default 50_000_000: clk cycles per second; ≥ 4.
- `FAST_DIV`, default 10: fast-set speed-up factor; 1 ≤ FAST_DIV ≤ CLK_FREQ/2.
- `DEBOUNCE_CYCLES`, default 500_000: stable cycles required to accept a key level (10 ms at 50 MHz); ≥ 1.
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startStopN`  in  1  raw push-button, active-low, asynchronous to clk; each press toggles run/stop.
- `clearN`  in  1  raw push-button, active-low, asynchronous to clk; each press clears.
- `fastSet`  in  1  slide switch; 1 selects terminal count CLK_FREQ/FAST_DIV (integer division).
- `CarryInSec`  out  1  registered seconds pulse, one clk cycle high per period.
- `running`  out  1  high in RUNNING state.
- `clearOutN`  out  1  registered active-low reset for the downstream counters.

## Operation
- Key path, per key: 2-FF synchronizer, then debouncer. The debounced level starts at 1. It takes the synced value after the synced value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any match restarts the count. A press event is a one-cycle pulse on a debounced 1→0 transition. Releases generate nothing.
- FSM states:
  - STOPPED (reset state).
  - RUNNING.
  - Start/stop event: STOPPED↔RUNNING.
  - Clear event: from any state → STOPPED. Divider cnt forced to 0.
  - Clear and start/stop events in the same cycle: clear wins, giving STOPPED.
- Divider:
  - TERM = fastSet ? CLK_FREQ/FAST_DIV : CLK_FREQ.
  - While RUNNING: if cnt ≥ TERM−1, cnt←0; else cnt←cnt+1.
  - The ≥ compare makes a mid-count switch to fast mode with cnt above the new terminal wrap on the next cycle.
  - STOPPED: cnt holds. Resume continues from the held value, so no period is lost or shortened.
  - Width: ceil(log2(CLK_FREQ)) bits, unsigned.
- `CarryInSec` ← (state==RUNNING && cnt ≥ TERM−1). This gives exactly one pulse per wrap. It is never high in STOPPED.
- `clearOutN` ← ~clear_event. It is low for exactly one cycle, the cycle after the clear event.

## Timing
- Reset values:
  - CarryInSec=0, running=0, clearOutN=0.
  - state=STOPPED, cnt=0.
  - Debounced levels=1; synchronizers=1; debounce counters=0.
- clearOutN rises on the first clk edge after resetN deasserts.
- Key latency: event pulse = 2 sync cycles + DEBOUNCE_CYCLES after the raw edge. `running` changes on the edge after the event.
- From `running` rising with cnt=0: first CarryInSec pulse after TERM cycles, then every TERM cycles. In normal mode the first second is a full second.
- Stop during a CarryInSec pulse cycle: the pulse completes, and the next cycle is low.
- resetN asserted mid-operation: every flop returns immediately to its reset value, without waiting for clk.

## Structure
- Shared package `clock_pkg`:
  - state typedef {STOPPED, RUNNING}.
  - Default constants CLK_FREQ_DEF=50_000_000 and DEBOUNCE_DEF=500_000, also used by minute/hour stages.
- Sub-module `key_debounce`, instantiated twice:
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, resetN, keyN → level, pressPulse.
  - Contents: synchronizer and debouncer.
- Top level holds the FSM, the divider and the output registers.

## Test plan
All scenarios use CLK_FREQ=10, FAST_DIV=5, DEBOUNCE_CYCLES=4.
- Reset, then startStopN held low 10 cycles → running=1 at cycle 7 after the press. CarryInSec pulses 10, 20, 30 cycles later, each exactly 1 cycle wide.
- Bounce: startStopN toggling every 2 cycles for 20 cycles, then left high → no event; running stays 0.
- Run 4 cycles, press stop, wait 50, press start → first pulse 6 cycles after resume. No pulse while stopped.
- Running with cnt=7, set fastSet=1 → pulse the next cycle (cnt≥1). Subsequent pulses every 2 cycles.
- Clear and start/stop pressed in the same cycle while RUNNING → state STOPPED, cnt=0, clearOutN low exactly 1 cycle, no CarryInSec.
- resetN pulsed low mid-period while running → CarryInSec, running and clearOutN go 0 immediately. After release, STOPPED with cnt=0.
